bcd_countdown_timer: RTL and testbench
======================================

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL have ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle, 1 Hz count-enable pulse.
- load  in  1  one-cycle pulse; captures preset_in.
- preset_in  in  16  BCD MM:SS as {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- start_pause  in  1  one-cycle pulse; toggles run/pause.
- clear  in  1  one-cycle pulse; returns to the loaded preset.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  current BCD value.
- running  out  1  high in RUN.
- expired  out  1  sticky, high in EXPIRED.
- done_pulse  out  1  one-cycle pulse when the value reaches 00:00.

REQ-002 SHALL have no parameters; the maximum value is fixed at 59:59.

Function
REQ-003 SHALL implement states IDLE, RUN, PAUSE and EXPIRED; all outputs registered.
REQ-004 Input priority SHALL be reset > clear > load > start_pause > tick.
REQ-005 On load, the block SHALL capture preset_in into a preset register and into the count, then enter IDLE.
- Digit value >9 clamps to 9.
- Tens digit >5 clamps to 5.
REQ-006 On clear, the count SHALL reload from the preset register; state goes to IDLE, expired goes low.
REQ-007 IDLE with start_pause SHALL move to RUN only if the count is not 00:00; otherwise the pulse is ignored.
REQ-008 start_pause SHALL toggle RUN and PAUSE; in EXPIRED it is ignored.
REQ-009 In RUN, tick SHALL decrement the count by one second.
- The new value is visible on the outputs the cycle after the tick.
- Ticks in IDLE, PAUSE and EXPIRED are ignored.
- A tick in the same cycle as start_pause from IDLE does not decrement.
REQ-010 Decrement SHALL be a BCD borrow chain:
- sec_ones 0->9 borrows from sec_tens.
- sec_tens 0->5 borrows from min_ones.
- min_ones 0->9 borrows from min_tens.
REQ-011 A tick at 00:01 in RUN SHALL set the count to 00:00, pulse done_pulse for exactly one cycle, and behave per REQ-017.
REQ-012 The count SHALL never underflow below 00:00 and never exceed 59:59.
REQ-013 The running output SHALL equal (state == RUN), and expired SHALL equal (state == EXPIRED).

Reset
REQ-014 Reset SHALL set all four digits to 0, the preset register to 00:00, state to IDLE, and running, expired and done_pulse to 0.
REQ-015 Reset asserted mid-count SHALL abort the count with no done_pulse, taking effect on the next edge.
REQ-016 Reset SHALL override every simultaneous input.

Configuration
REQ-017 Macro COUNTDOWN_AUTORELOAD_EN SHALL control the behaviour at 00:00.
- Not defined: reaching 00:00 enters EXPIRED. The block stays there until clear, load or reset.
- Defined: the block stays in RUN and expired never asserts. The next tick at 00:00 reloads the preset register into the count, and counting continues. done_pulse fires once per period.
REQ-018 Macro presence SHALL NOT change the port list.

Verification
REQ-019 Load 01:00, start, 1 tick -> 00:59; 60 ticks total -> 00:00, done_pulse one cycle; expired=1 when the macro is undefined.
REQ-020 Load 10:00, start, 1 tick -> 09:59 (full borrow chain across all digits).
REQ-021 Load 0x7A99 -> preset clamps to 59:59; start with count 00:00 after reset -> stays IDLE, running=0.
REQ-022 Load 00:05, start, 2 ticks, pause, 3 ticks -> 00:03 held; start, 3 ticks -> 00:00, done_pulse.
REQ-023 Load 00:03, start, 1 tick, clear and tick in the same cycle -> 00:03, IDLE; reset during RUN -> 00:00, all outputs 0, no done_pulse.
REQ-024 Macro defined, load 00:02, start, 2 ticks -> 00:00, done_pulse, running=1; next tick -> 00:02; 2 more ticks -> second done_pulse.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - MM:SS BCD countdown timer (max 59:59) with run/pause/expire FSM.
// Define COUNTDOWN_AUTORELOAD_EN to reload the preset at 00:00 instead of expiring.
module bcd_countdown_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] preset_in,
  input  logic        start_pause,
  input  logic        clear,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        running,
  output logic        expired,
  output logic        done_pulse
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] preset_q, preset_d;
  logic        done_q, done_d;
  logic [15:0] preset_clamped;
  logic [15:0] count_dec;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // Borrow chain; only applied to a nonzero count, so min_tens never wraps.
  function automatic logic [15:0] dec_bcd(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd0) begin
      r[3:0] = c[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (c[7:4] != 4'd0) begin
        r[7:4] = c[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (c[11:8] != 4'd0) begin
          r[11:8] = c[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = c[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign preset_clamped = {clamp_digit(preset_in[15:12], 4'd5),
                           clamp_digit(preset_in[11:8],  4'd9),
                           clamp_digit(preset_in[7:4],   4'd5),
                           clamp_digit(preset_in[3:0],   4'd9)};
  assign count_dec = dec_bcd(count_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= 16'h0000;
      preset_q <= 16'h0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      preset_q <= preset_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    if (clear) begin
      count_d = preset_q;
      state_d = S_IDLE;
    end else if (load) begin
      preset_d = preset_clamped;
      count_d  = preset_clamped;
      state_d  = S_IDLE;
    end else if (start_pause) begin
      case (state_q)
        S_IDLE:  if (count_q != 16'h0000) state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end else if (tick && (state_q == S_RUN)) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      if (count_q == 16'h0000) begin
        count_d = preset_q;
      end else begin
        count_d = count_dec;
        if (count_dec == 16'h0000) done_d = 1'b1;
      end
`else
      if (count_q != 16'h0000) begin
        count_d = count_dec;
        if (count_dec == 16'h0000) begin
          done_d  = 1'b1;
          state_d = S_EXPIRED;
        end
      end
`endif
    end
  end

  always_comb begin
    min_tens   = count_q[15:12];
    min_ones   = count_q[11:8];
    sec_tens   = count_q[7:4];
    sec_ones   = count_q[3:0];
    running    = (state_q == S_RUN);
    expired    = (state_q == S_EXPIRED);
    done_pulse = done_q;
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset_in = 16'h0000;
  logic        start_pause = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
  logic        running, expired, done_pulse;
  logic [15:0] cnt;

  int n_vec = 0;
  int n_err = 0;
  logic early_done;

  bcd_countdown_timer dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .preset_in  (preset_in),
    .start_pause(start_pause),
    .clear      (clear),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running),
    .expired    (expired),
    .done_pulse (done_pulse)
  );

  assign cnt = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  task automatic cyc(input logic t, input logic ld, input logic sp, input logic cl,
                     input logic rs, input logic [15:0] p);
    tick = t; load = ld; start_pause = sp; clear = cl; reset = rs; preset_in = p;
    @(posedge clk);
    #1;
    tick = 1'b0; load = 1'b0; start_pause = 1'b0; clear = 1'b0; reset = 1'b0;
  endtask

  task automatic do_tick();   cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); endtask
  task automatic do_start();  cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); endtask
  task automatic do_idle();   cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); endtask
  task automatic do_load(input logic [15:0] p); cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, p); endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
    chk("rst_count",   cnt, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_expired", {15'd0, expired}, 16'd0);
    chk("rst_done",    {15'd0, done_pulse}, 16'd0);

    do_start();
    chk("start_at_zero_running", {15'd0, running}, 16'd0);

    do_load(16'h7A99);
    chk("clamp_7a99", cnt, 16'h5959);
    do_tick();
    chk("idle_tick_ignored", cnt, 16'h5959);

    do_load(16'h1000);
    do_start();
    chk("run_1000", {15'd0, running}, 16'd1);
    do_tick();
    chk("borrow_1000", cnt, 16'h0959);

    do_load(16'h0100);
    chk("load_from_run_idle", {15'd0, running}, 16'd0);
    do_start();
    do_tick();
    chk("borrow_0100", cnt, 16'h0059);
    early_done = 1'b0;
    for (int i = 0; i < 58; i++) begin
      do_tick();
      if (done_pulse) early_done = 1'b1;
    end
    chk("count_0001", cnt, 16'h0001);
    chk("no_early_done", {15'd0, early_done}, 16'd0);
    do_tick();
    chk("reach_zero", cnt, 16'h0000);
    chk("done_at_zero", {15'd0, done_pulse}, 16'd1);
`ifdef COUNTDOWN_AUTORELOAD_EN
    chk("auto_running_at_zero", {15'd0, running}, 16'd1);
    chk("auto_no_expired", {15'd0, expired}, 16'd0);
`else
    chk("expired_at_zero", {15'd0, expired}, 16'd1);
    chk("not_running_at_zero", {15'd0, running}, 16'd0);
`endif
    do_idle();
    chk("done_one_cycle", {15'd0, done_pulse}, 16'd0);
`ifndef COUNTDOWN_AUTORELOAD_EN
    do_start();
    chk("expired_ignores_start", {15'd0, expired}, 16'd1);
`endif

    do_load(16'h0005);
    chk("load_clears_expired", {15'd0, expired}, 16'd0);
    do_start();
    do_tick();
    do_tick();
    chk("run_0003", cnt, 16'h0003);
    do_start();
    chk("paused", {15'd0, running}, 16'd0);
    do_tick(); do_tick(); do_tick();
    chk("pause_holds", cnt, 16'h0003);
    do_start();
    chk("resumed", {15'd0, running}, 16'd1);
    do_tick(); do_tick();
    chk("resume_0001", cnt, 16'h0001);
    do_tick();
    chk("resume_zero", cnt, 16'h0000);
    chk("resume_done", {15'd0, done_pulse}, 16'd1);

    do_load(16'h0003);
    do_start();
    do_tick();
    chk("run_0002", cnt, 16'h0002);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("clear_tick_count", cnt, 16'h0003);
    chk("clear_idle", {15'd0, running}, 16'd0);
    do_start();
    do_tick();
    chk("run_again_0002", cnt, 16'h0002);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("rst_run_count", cnt, 16'h0000);
    chk("rst_run_flags", {13'd0, running, expired, done_pulse}, 16'd0);

    do_load(16'h0001);
    do_start();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("rst_at_0001_no_done", {15'd0, done_pulse}, 16'd0);
    chk("rst_at_0001_count", cnt, 16'h0000);

    do_load(16'h0005);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("start_tick_running", {15'd0, running}, 16'd1);
    chk("start_tick_no_dec", cnt, 16'h0005);

`ifdef COUNTDOWN_AUTORELOAD_EN
    do_load(16'h0002);
    do_start();
    do_tick();
    do_tick();
    chk("auto_zero", cnt, 16'h0000);
    chk("auto_done1", {15'd0, done_pulse}, 16'd1);
    chk("auto_running", {15'd0, running}, 16'd1);
    do_tick();
    chk("auto_reload", cnt, 16'h0002);
    chk("auto_reload_no_done", {15'd0, done_pulse}, 16'd0);
    do_tick();
    do_tick();
    chk("auto_done2", {15'd0, done_pulse}, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
